// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 capture block: FSM states, the pixel word carried
// through the output FIFO, and the default FIFO depth.
package ov7670_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        sol;
    } pixel_t;

    localparam int PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/ov7670_capture_sync_fifo.sv
// Single-clock FIFO, combinational read port, 1-cycle write-to-empty-flag latency.
// A write while full is accepted only when a read retires an entry in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream to RGB565 pixel stream; pixel valid 1 clk after its low-byte strobe.
// Valid/ready output through a small FIFO; a pixel arriving while it is full and not popping is dropped and flagged.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MAX_X      = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        plk,
    input  logic [7:0]  D,
    input  logic        vsync,
    input  logic        hsync,
    input  logic        enable,
    output logic [15:0] m_data,
    output logic        m_sof,
    output logic        m_sol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        frame_done,
    output logic        overflow,
    input  logic        clear_ovf
);

    localparam int XW = $clog2(MAX_X);

    logic          plk_s1_q, plk_s1_d, plk_s2_q, plk_s2_d, plk_prev_q, plk_prev_d;
    logic          vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_prev_q, vs_prev_d;
    logic          hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_prev_q, hs_prev_d;
    logic [7:0]    d_s1_q, d_s1_d, d_s2_q, d_s2_d;
    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic          sof_pend_q, sof_pend_d;
    logic [XW-1:0] x_q, x_d;
    logic          ovf_q, ovf_d;

    logic          strobe, byte_vld, vs_rise, vs_fall, hs_rise, hs_fall;
    logic          phase_cur;
    logic [XW-1:0] x_cur;
    logic          push_req, drop, rd_en, fifo_full, fifo_empty;
    pixel_t        push_pix, rd_pix;

    always_comb begin
        plk_s1_d   = plk;
        plk_s2_d   = plk_s1_q;
        plk_prev_d = plk_s2_q;
        vs_s1_d    = vsync;
        vs_s2_d    = vs_s1_q;
        vs_prev_d  = vs_s2_q;
        hs_s1_d    = hsync;
        hs_s2_d    = hs_s1_q;
        hs_prev_d  = hs_s2_q;
        d_s1_d     = D;
        d_s2_d     = d_s1_q;
    end

    assign strobe   = plk_s2_q & ~plk_prev_q;
    assign byte_vld = strobe & hs_s2_q;
    assign vs_rise  = vs_s2_q & ~vs_prev_q;
    assign vs_fall  = ~vs_s2_q & vs_prev_q;
    assign hs_rise  = hs_s2_q & ~hs_prev_q;
    assign hs_fall  = ~hs_s2_q & hs_prev_q;

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE:    if (enable && vs_rise) state_d = WAIT_VS;
            WAIT_VS: if (vs_fall) state_d = ACTIVE;
            ACTIVE: begin
                if (vs_rise) begin
                    frame_done = 1'b1;
                    state_d    = enable ? WAIT_VS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An hsync rise in the same cycle as a byte strobe must already apply to that byte.
    assign phase_cur = hs_rise ? 1'b0 : phase_q;
    assign x_cur     = hs_rise ? '0 : x_q;

    always_comb begin
        phase_d    = phase_q;
        hi_d       = hi_q;
        sof_pend_d = sof_pend_q;
        x_d        = x_q;
        push_req   = 1'b0;
        push_pix   = '0;
        if (state_q == WAIT_VS && vs_fall) sof_pend_d = 1'b1;
        if (state_q == ACTIVE && !vs_rise) begin
            phase_d = hs_fall ? 1'b0 : phase_cur;
            x_d     = x_cur;
            if (byte_vld) begin
                if (!phase_cur) begin
                    hi_d    = d_s2_q;
                    phase_d = 1'b1;
                end else begin
                    push_req      = 1'b1;
                    push_pix.data = {hi_q, d_s2_q};
                    push_pix.sof  = sof_pend_q;
                    push_pix.sol  = (x_cur == '0) || sof_pend_q;
                    phase_d       = 1'b0;
                    sof_pend_d    = 1'b0;
                    if (x_cur != XW'(MAX_X - 1)) x_d = x_cur + XW'(1);
                end
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    assign rd_en = m_valid & m_ready;
    assign drop  = push_req & fifo_full & ~rd_en;

    always_comb begin
        ovf_d = ovf_q;
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            plk_s1_q   <= 1'b0;
            plk_s2_q   <= 1'b0;
            plk_prev_q <= 1'b0;
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            vs_prev_q  <= 1'b0;
            hs_s1_q    <= 1'b0;
            hs_s2_q    <= 1'b0;
            hs_prev_q  <= 1'b0;
            d_s1_q     <= '0;
            d_s2_q     <= '0;
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            sof_pend_q <= 1'b0;
            x_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            plk_s1_q   <= plk_s1_d;
            plk_s2_q   <= plk_s2_d;
            plk_prev_q <= plk_prev_d;
            vs_s1_q    <= vs_s1_d;
            vs_s2_q    <= vs_s2_d;
            vs_prev_q  <= vs_prev_d;
            hs_s1_q    <= hs_s1_d;
            hs_s2_q    <= hs_s2_d;
            hs_prev_q  <= hs_prev_d;
            d_s1_q     <= d_s1_d;
            d_s2_q     <= d_s2_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            sof_pend_q <= sof_pend_d;
            x_q        <= x_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_req),
        .wr_data (push_pix),
        .rd_en   (rd_en),
        .rd_data (rd_pix),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Storage is unreset, so the payload is masked whenever nothing is valid.
    assign m_valid  = ~fifo_empty;
    assign m_data   = m_valid ? rd_pix.data : '0;
    assign m_sof    = m_valid & rd_pix.sof;
    assign m_sol    = m_valid & rd_pix.sol;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: camera-side bytes driven as plain data in the clk
// domain, accepted pixels collected on the falling edge as {data, sof, sol}.
module tb_ov7670_capture;

    logic        clk;
    logic        rst;
    logic        plk;
    logic [7:0]  D;
    logic        vsync;
    logic        hsync;
    logic        enable;
    logic [15:0] m_data;
    logic        m_sof;
    logic        m_sol;
    logic        m_valid;
    logic        m_ready;
    logic        frame_done;
    logic        overflow;
    logic        clear_ovf;

    int          checks;
    int          errors;
    int          fd_cnt;
    logic [17:0] got_q [$];

    ov7670_capture #(
        .FIFO_DEPTH (4),
        .MAX_X      (640)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .plk        (plk),
        .D          (D),
        .vsync      (vsync),
        .hsync      (hsync),
        .enable     (enable),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_sol      (m_sol),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial fd_cnt = 0;
    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back({m_data, m_sof, m_sol});
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        D   = b;
        plk = 1'b0;
        step(2);
        plk = 1'b1;
        step(2);
    endtask

    task automatic send_line(input logic [7:0] first, input int n, input logic [7:0] inc);
        logic [7:0] b;
        b     = first;
        hsync = 1'b1;
        step(2);
        for (int i = 0; i < n; i++) begin
            send_byte(b);
            b = b + inc;
        end
        plk = 1'b0;
        step(1);
        hsync = 1'b0;
        step(4);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        step(4);
        vsync = 1'b0;
        step(4);
    endtask

    task automatic check_pixels(input string name, input int base, input int n, input logic [17:0] exp [8]);
        checks++;
        if (got_q.size() - base != n) begin
            errors++;
            $display("FAIL %s count got %0d exp %0d", name, got_q.size() - base, n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[base + i] !== exp[i]) begin
                errors++;
                $display("FAIL %s pixel%0d got %h exp %h", name, i, got_q[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++; if (m_valid !== 1'b0)     begin errors++; $display("FAIL reset m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 16'h0)     begin errors++; $display("FAIL reset m_data got %h exp 0000", m_data); end
        checks++; if (m_sof !== 1'b0)       begin errors++; $display("FAIL reset m_sof got %b exp 0", m_sof); end
        checks++; if (m_sol !== 1'b0)       begin errors++; $display("FAIL reset m_sol got %b exp 0", m_sol); end
        checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset overflow got %b exp 0", overflow); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic_frame();
        int base, fdb;
        logic [17:0] exp [8];
        exp = '{{16'h1234, 2'b11}, {16'h5678, 2'b00}, {16'h9ABC, 2'b00}, {16'hDE00, 2'b00},
                {16'h2143, 2'b01}, {16'h6587, 2'b00}, {16'hA9CB, 2'b00}, {16'hED0F, 2'b00}};
        enable  = 1'b1;
        m_ready = 1'b1;
        base = got_q.size();
        fdb  = fd_cnt;
        vsync_pulse();
        send_line(8'h12, 8, 8'h22);
        send_line(8'h21, 8, 8'h22);
        vsync_pulse();
        step(2);
        check_pixels("basic", base, 8, exp);
        checks++;
        if (fd_cnt - fdb != 1) begin errors++; $display("FAIL basic frame_done got %0d exp 1", fd_cnt - fdb); end
    endtask

    task automatic test_overflow();
        int base;
        logic [17:0] exp [8];
        exp = '{{16'h0102, 2'b11}, {16'h0304, 2'b00}, {16'h0506, 2'b00}, {16'h0708, 2'b00},
                18'h0, 18'h0, 18'h0, 18'h0};
        m_ready = 1'b0;
        base = got_q.size();
        vsync_pulse();
        send_line(8'h01, 16, 8'h01);
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf set got %b exp 1", overflow); end
        checks++; if (m_valid !== 1'b1)   begin errors++; $display("FAIL ovf stall valid got %b exp 1", m_valid); end
        checks++; if (m_data !== 16'h0102) begin errors++; $display("FAIL ovf stall data got %h exp 0102", m_data); end
        vsync_pulse();
        m_ready = 1'b1;
        step(6);
        check_pixels("ovf", base, 4, exp);
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf sticky got %b exp 1", overflow); end
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf clear got %b exp 0", overflow); end
    endtask

    task automatic test_odd_line();
        int base;
        logic [17:0] exp [8];
        exp = '{{16'hA0A1, 2'b11}, {16'hA2A3, 2'b00}, {16'hA4A5, 2'b00}, {16'hB0B1, 2'b01},
                {16'hB2B3, 2'b00}, 18'h0, 18'h0, 18'h0};
        m_ready = 1'b1;
        base = got_q.size();
        vsync_pulse();
        send_line(8'hA0, 7, 8'h01);
        send_line(8'hB0, 4, 8'h01);
        vsync_pulse();
        step(2);
        check_pixels("oddline", base, 5, exp);
    endtask

    task automatic test_enable();
        int base;
        logic [17:0] exp [8];
        exp = '{{16'hD0D1, 2'b11}, {16'hD2D3, 2'b00}, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
        m_ready = 1'b1;
        enable  = 1'b0;
        base = got_q.size();
        vsync_pulse();
        send_line(8'hC0, 4, 8'h01);
        checks++;
        if (got_q.size() != base) begin errors++; $display("FAIL enable off pixels got %0d exp 0", got_q.size() - base); end
        enable = 1'b1;
        vsync_pulse();
        base = got_q.size();
        send_line(8'hD0, 4, 8'h01);
        vsync_pulse();
        step(2);
        check_pixels("enable on", base, 2, exp);
    endtask

    task automatic test_reset_mid_line();
        int base;
        logic [17:0] exp [8];
        exp = '{{16'h5051, 2'b11}, {16'h5253, 2'b00}, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
        m_ready = 1'b0;
        vsync_pulse();
        hsync = 1'b1;
        step(2);
        send_byte(8'hE0);
        send_byte(8'hE1);
        send_byte(8'hE2);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL midrst pre valid got %b exp 1", m_valid); end
        rst = 1'b1;
        step(1);
        checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL midrst m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 16'h0)    begin errors++; $display("FAIL midrst m_data got %h exp 0000", m_data); end
        checks++; if (m_sof !== 1'b0 || m_sol !== 1'b0) begin errors++; $display("FAIL midrst flags got %b%b exp 00", m_sof, m_sol); end
        checks++; if (frame_done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst fd/ovf got %b%b exp 00", frame_done, overflow); end
        rst     = 1'b0;
        m_ready = 1'b1;
        base = got_q.size();
        send_byte(8'hE3);
        send_byte(8'hE4);
        send_byte(8'hE5);
        plk = 1'b0;
        step(1);
        hsync = 1'b0;
        step(4);
        send_line(8'hF0, 4, 8'h01);
        checks++;
        if (got_q.size() != base) begin errors++; $display("FAIL midrst ignored got %0d exp 0", got_q.size() - base); end
        vsync_pulse();
        send_line(8'h50, 4, 8'h01);
        vsync_pulse();
        step(2);
        check_pixels("midrst next", base, 2, exp);
    endtask

    task automatic test_full_pop_push();
        int base;
        logic [17:0] exp [8];
        exp = '{{16'h6061, 2'b11}, {16'h6263, 2'b00}, {16'h6465, 2'b00}, {16'h6667, 2'b00},
                {16'h6869, 2'b00}, 18'h0, 18'h0, 18'h0};
        m_ready = 1'b0;
        base = got_q.size();
        vsync_pulse();
        hsync = 1'b1;
        step(2);
        send_byte(8'h60);
        D   = 8'h61;
        plk = 1'b0;
        step(2);
        plk = 1'b1;
        step(2);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL latency strobe valid got %b exp 0", m_valid); end
        step(1);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL latency next valid got %b exp 1", m_valid); end
        step(1);
        for (int i = 0; i < 6; i++) send_byte(8'h62 + 8'(i));
        send_byte(8'h68);
        D   = 8'h69;
        plk = 1'b0;
        step(2);
        plk = 1'b1;
        step(2);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        step(1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full popush overflow got %b exp 0", overflow); end
        checks++;
        if (got_q.size() - base != 1) begin errors++; $display("FAIL full popush popped got %0d exp 1", got_q.size() - base); end
        plk = 1'b0;
        step(1);
        hsync = 1'b0;
        step(4);
        m_ready = 1'b1;
        step(6);
        check_pixels("full popush", base, 5, exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        plk       = 1'b0;
        D         = 8'h00;
        vsync     = 1'b0;
        hsync     = 1'b0;
        enable    = 1'b0;
        m_ready   = 1'b0;
        clear_ovf = 1'b0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_odd_line();
        test_enable();
        test_reset_mid_line();
        test_full_pop_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
